// File: rtl/wb_arb_pkg.sv
// Arbiter-local definitions: FSM encoding, master index constants and watchdog fill data.
package wb_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GNT0 = 2'd1;
   localparam logic [1:0] ST_GNT1 = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      GNT0 = ST_GNT0,
      GNT1 = ST_GNT1
   } arb_state_e;

   localparam logic ARB_M0 = 1'b0;
   localparam logic ARB_M1 = 1'b1;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: transfer data-width encoding used by every bus port.
package wb_pkg;

   typedef enum logic [1:0] {
      eDW_B = 2'd0,
      eDW_H = 2'd1,
      eDW_W = 2'd2
   } wb_width_e;

endpackage

// File: rtl/wishbone_if.sv
// Wishbone bus bundle with master/slave views as seen from each side of a link.
interface WISHBONE_IF;
   import wb_pkg::*;

   logic [31:0] addr;
   logic        we;
   logic        stb;
   logic        cyc;
   wb_width_e   width;
   logic [31:0] data_write;
   logic [31:0] data_read;
   logic        ack;

   modport master (
      output addr, we, stb, cyc, width, data_write,
      input  data_read, ack
   );

   modport slave (
      input  addr, we, stb, cyc, width, data_write,
      output data_read, ack
   );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Grant watchdog: counts un-acked cycles of a granted transfer and fires a one-cycle pulse.
module wb_arb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic active,
   input  logic ack,
   output logic fire
);

   localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] count;

   assign fire = active && !ack && (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (start || ack || fire) begin
         count <= '0;
      end else if (active) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master (fetch M0, data M1) to one-slave Wishbone arbiter with grant held until cyc drops.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module wb_mem_arbiter
   import wb_pkg::*;
   import wb_arb_pkg::*;
#(
   parameter int unsigned PRIORITY_MODE  = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   WISHBONE_IF.slave  m0_wb,
   WISHBONE_IF.slave  m1_wb,
   WISHBONE_IF.master s_wb,
   output logic [1:0] oGrant,
   output logic       oTimeout
);

   arb_state_e state;
   arb_state_e state_nxt;
   logic       last_win;
   logic       gnt0;
   logic       gnt1;
   logic       fire;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_wb.cyc && m1_wb.cyc) begin
               if (PRIORITY_MODE == 0) begin
                  state_nxt = GNT1;
               end else begin
                  state_nxt = (last_win == ARB_M1) ? GNT0 : GNT1;
               end
            end else if (m0_wb.cyc) begin
               state_nxt = GNT0;
            end else if (m1_wb.cyc) begin
               state_nxt = GNT1;
            end
         end
         GNT0:    if (!m0_wb.cyc) state_nxt = IDLE;
         GNT1:    if (!m1_wb.cyc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_win <= ARB_M1;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt == GNT0) last_win <= ARB_M0;
         if (state == IDLE && state_nxt == GNT1) last_win <= ARB_M1;
      end
   end

   // Routing decodes straight from the registered state, so an async reset drops the bus at once.
   assign gnt0 = (state == GNT0);
   assign gnt1 = (state == GNT1);

   assign oGrant[ARB_M0] = gnt0;
   assign oGrant[ARB_M1] = gnt1;

   assign s_wb.addr       = gnt0 ? m0_wb.addr       : gnt1 ? m1_wb.addr       : '0;
   assign s_wb.we         = gnt0 ? m0_wb.we         : gnt1 ? m1_wb.we         : 1'b0;
   assign s_wb.stb        = gnt0 ? m0_wb.stb        : gnt1 ? m1_wb.stb        : 1'b0;
   assign s_wb.cyc        = gnt0 ? m0_wb.cyc        : gnt1 ? m1_wb.cyc        : 1'b0;
   assign s_wb.width      = gnt0 ? m0_wb.width      : gnt1 ? m1_wb.width      : eDW_W;
   assign s_wb.data_write = gnt0 ? m0_wb.data_write : gnt1 ? m1_wb.data_write : '0;

   assign m0_wb.ack       = gnt0 && (s_wb.ack || fire);
   assign m1_wb.ack       = gnt1 && (s_wb.ack || fire);
   assign m0_wb.data_read = !gnt0 ? '0 : fire ? TIMEOUT_DATA : s_wb.data_read;
   assign m1_wb.data_read = !gnt1 ? '0 : fire ? TIMEOUT_DATA : s_wb.data_read;

`ifdef ARB_TIMEOUT_EN
   wb_arb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk   (clk),
      .rst_n (rst_n),
      .start ((state == IDLE) && (state_nxt != IDLE)),
      .active(state != IDLE),
      .ack   (s_wb.ack),
      .fire  (fire)
   );
`else
   // No watchdog: the limit only keeps the parameter referenced; the result is always 0.
   assign fire = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   assign oTimeout = fire;

endmodule
